// File: rtl/peripheral_mutex_n_if.sv
// Operation/peripheral bus between the requesting nodes and peripheral_mutex_n.
// master = node side (drives operation words), slave = arbiter side.
interface peripheral_mutex_n_if #(
   parameter int NUM_NODES = 4,
   parameter int OP_WIDTH  = 16,
   parameter int OUT_WIDTH = 8
);
   localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

   logic [NUM_NODES*OP_WIDTH-1:0] in_op;
   logic [OUT_WIDTH-1:0]          out_peripheral;
   logic                          locked;
   logic [IW-1:0]                 owner;
   logic                          timeout_pulse;

   modport master (
      output in_op,
      input  out_peripheral,
      input  locked,
      input  owner,
      input  timeout_pulse
   );

   modport slave (
      input  in_op,
      output out_peripheral,
      output locked,
      output owner,
      output timeout_pulse
   );
endinterface

// File: rtl/peripheral_mutex_n.sv
// N-node priority/round-robin mutex in front of a single peripheral driver.
// Optional hold-timeout watchdog enabled by defining PERIPH_MUTEX_TIMEOUT_EN.
module peripheral_mutex_n #(
   parameter int         NUM_NODES    = 4,
   parameter int         OP_WIDTH     = 16,
   parameter int         OUT_WIDTH    = 8,
   parameter logic [3:0] FUNC_TAG     = 4'b1010,
   parameter int         HOLD_TIMEOUT = 1024
) (
   input logic                 CLK,
   input logic                 RST,
   peripheral_mutex_n_if.slave bus
);
   localparam int IW = (NUM_NODES > 1) ? $clog2(NUM_NODES) : 1;

   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HELD = 1'b1;

   if ((NUM_NODES < 2) || (NUM_NODES > 16) || (OP_WIDTH < 16) ||
       (OUT_WIDTH > OP_WIDTH) || (HOLD_TIMEOUT < 2)) begin : g_bad_cfg
      $error("peripheral_mutex_n: illegal parameter combination");
   end

   // Control words need {F, FUNC_TAG} in [15:8] and zeros above bit 15.
   function automatic logic is_ctrl(input logic [OP_WIDTH-1:0] w);
      return ((w >> 32'd16) == {OP_WIDTH{1'b0}}) &&
             (w[15:12] == 4'hF) && (w[11:8] == FUNC_TAG);
   endfunction

   function automatic logic is_start(input logic [OP_WIDTH-1:0] w);
      return is_ctrl(w) && (w[7:4] == 4'h0) && (w[3:0] != 4'h0);
   endfunction

   function automatic logic is_stop(input logic [OP_WIDTH-1:0] w);
      return is_ctrl(w) && (w[7:0] == 8'hFF);
   endfunction

   function automatic logic is_null(input logic [OP_WIDTH-1:0] w);
      return (w == {OP_WIDTH{1'b0}});
   endfunction

   logic [0:0]           state_r;
   logic [IW-1:0]        owner_r;
   logic [IW-1:0]        rr_ptr_r;
   logic [OUT_WIDTH-1:0] out_r;
   logic                 locked_r;

   logic [NUM_NODES-1:0] req_s;
   logic [3:0]           prio_s [NUM_NODES];
   logic [3:0]           best_prio_s;
   logic                 win_found_s;
   logic [IW-1:0]        win_idx_s;
   logic [IW-1:0]        rr_next_s;
   logic [OP_WIDTH-1:0]  owner_word_s;
   logic                 own_start_s;
   logic                 own_stop_s;
   logic                 own_null_s;
   logic                 timeout_hit_s;

   // Requester decode and highest requested priority
   always_comb begin
      best_prio_s = 4'h0;
      for (int k = 0; k < NUM_NODES; k++) begin
         req_s[k]  = is_start(bus.in_op[k*OP_WIDTH +: OP_WIDTH]);
         prio_s[k] = bus.in_op[k*OP_WIDTH +: 4];
         if (req_s[k] && (prio_s[k] > best_prio_s)) begin
            best_prio_s = prio_s[k];
         end else begin
            best_prio_s = best_prio_s;
         end
      end
   end

   // First top-priority requester at or after rr_ptr, wrapping upward
   always_comb begin
      int idx;
      idx         = 0;
      win_found_s = 1'b0;
      win_idx_s   = {IW{1'b0}};
      for (int i = 0; i < NUM_NODES; i++) begin
         idx = int'(rr_ptr_r) + i;
         idx = (idx >= NUM_NODES) ? (idx - NUM_NODES) : idx;
         if (!win_found_s && req_s[idx] && (prio_s[idx] == best_prio_s)) begin
            win_found_s = 1'b1;
            win_idx_s   = IW'(idx);
         end else begin
            win_found_s = win_found_s;
         end
      end
      rr_next_s = (win_idx_s == IW'(NUM_NODES - 1)) ? {IW{1'b0}} : (win_idx_s + IW'(1));
   end

   // Only the holder's word matters while HELD
   always_comb begin
      owner_word_s = bus.in_op[int'(owner_r)*OP_WIDTH +: OP_WIDTH];
      own_start_s  = is_start(owner_word_s);
      own_stop_s   = is_stop(owner_word_s);
      own_null_s   = is_null(owner_word_s);
   end

`ifdef PERIPH_MUTEX_TIMEOUT_EN
   localparam int CW = $clog2(HOLD_TIMEOUT);

   logic [CW-1:0] idle_cnt_r;
   logic          timeout_pulse_r;

   assign timeout_hit_s = (state_r == ST_HELD) && own_null_s &&
                          (idle_cnt_r == CW'(HOLD_TIMEOUT - 1));

   // Null-word run counter; anything but a continuing null run clears it
   always_ff @(posedge CLK) begin
      if (RST) begin
         idle_cnt_r      <= {CW{1'b0}};
         timeout_pulse_r <= 1'b0;
      end else begin
         timeout_pulse_r <= timeout_hit_s;
         if ((state_r == ST_HELD) && own_null_s && !timeout_hit_s) begin
            idle_cnt_r <= idle_cnt_r + CW'(1);
         end else begin
            idle_cnt_r <= {CW{1'b0}};
         end
      end
   end

   assign bus.timeout_pulse = timeout_pulse_r;
`else
   assign timeout_hit_s     = 1'b0;
   assign bus.timeout_pulse = 1'b0;
`endif

   // Lock FSM and registered peripheral drive
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_r  <= ST_IDLE;
         owner_r  <= {IW{1'b0}};
         rr_ptr_r <= {IW{1'b0}};
         out_r    <= {OUT_WIDTH{1'b0}};
         locked_r <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               out_r <= {OUT_WIDTH{1'b0}};
               if (win_found_s) begin
                  owner_r  <= win_idx_s;
                  rr_ptr_r <= rr_next_s;
                  locked_r <= 1'b1;
                  state_r  <= ST_HELD;
               end
            end
            ST_HELD: begin
               if (own_stop_s) begin
                  locked_r <= 1'b0;
                  state_r  <= ST_IDLE;
               end else if (timeout_hit_s) begin
                  out_r    <= {OUT_WIDTH{1'b0}};
                  locked_r <= 1'b0;
                  state_r  <= ST_IDLE;
               end else if (own_start_s) begin
                  out_r <= {OUT_WIDTH{1'b0}};
               end else if (!own_null_s) begin
                  out_r <= owner_word_s[OUT_WIDTH-1:0];
               end
            end
            default: begin
               out_r    <= {OUT_WIDTH{1'b0}};
               locked_r <= 1'b0;
               state_r  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.out_peripheral = out_r;
   assign bus.locked         = locked_r;
   assign bus.owner          = owner_r;
endmodule

// File: tb/tb_peripheral_mutex_n.sv
// Directed + randomized bench for peripheral_mutex_n against a cycle-level
// behavioural model of the lock rules (works with or without PERIPH_MUTEX_TIMEOUT_EN).
module tb_peripheral_mutex_n;
   localparam int NN   = 4;
   localparam int OPW  = 16;
   localparam int OUTW = 8;
   localparam int HT   = 8;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   peripheral_mutex_n_if #(.NUM_NODES(NN), .OP_WIDTH(OPW), .OUT_WIDTH(OUTW)) bus ();

   peripheral_mutex_n #(
      .NUM_NODES(NN), .OP_WIDTH(OPW), .OUT_WIDTH(OUTW),
      .FUNC_TAG(4'hA), .HOLD_TIMEOUT(HT)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus.slave)
   );

   int vectors     = 0;
   int miscompares = 0;

   int ops [NN];

   int m_locked, m_owner, m_out, m_tp, m_rr, m_cnt;

   function automatic bit w_start(int w);
      return ((w >> 8) == 'hFA) && ((w & 'hF0) == 0) && ((w & 'hF) != 0);
   endfunction

   function automatic bit w_stop(int w);
      return w == 'hFAFF;
   endfunction

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_step();
      int best, bestd, win, d, w;
      if (RST) begin
         m_locked = 0; m_owner = 0; m_out = 0; m_tp = 0; m_rr = 0; m_cnt = 0;
      end else if (m_locked == 0) begin
         m_out = 0; m_tp = 0; m_cnt = 0;
         best = 0; bestd = NN; win = -1;
         for (int k = 0; k < NN; k++) begin
            if (w_start(ops[k])) begin
               d = (k - m_rr + NN) % NN;
               if (((ops[k] & 15) > best) || (((ops[k] & 15) == best) && (d < bestd))) begin
                  best = ops[k] & 15; bestd = d; win = k;
               end
            end
         end
         if (win >= 0) begin
            m_locked = 1; m_owner = win; m_rr = (win + 1) % NN;
         end
      end else begin
         w = ops[m_owner];
         m_tp = 0;
         if (w_stop(w)) begin
            m_locked = 0; m_cnt = 0;
         end else if (w_start(w)) begin
            m_out = 0; m_cnt = 0;
         end else if (w == 0) begin
`ifdef PERIPH_MUTEX_TIMEOUT_EN
            if (m_cnt == HT - 1) begin
               m_locked = 0; m_out = 0; m_tp = 1; m_cnt = 0;
            end else begin
               m_cnt++;
            end
`endif
         end else begin
            m_out = w & 'hFF; m_cnt = 0;
         end
      end
   endtask

   task automatic tick();
      for (int k = 0; k < NN; k++) bus.in_op[k*OPW +: OPW] = ops[k][OPW-1:0];
      @(posedge CLK);
      model_step();
      #1;
      chk("locked", 32'(bus.locked), 32'(m_locked));
      chk("out_peripheral", 32'(bus.out_peripheral), 32'(m_out));
      chk("timeout_pulse", 32'(bus.timeout_pulse), 32'(m_tp));
      if (m_locked != 0) chk("owner", 32'(bus.owner), 32'(m_owner));
   endtask

   task automatic clear_ops();
      for (int k = 0; k < NN; k++) ops[k] = 0;
   endtask

   initial begin
      int r;
      clear_ops();
      bus.in_op = '0;

      // reset and quiet bus
      RST = 1'b1; tick(); tick();
      chk("reset_owner", 32'(bus.owner), 32'd0);
      RST = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      chk("quiet_locked", 32'(bus.locked), 32'd0);

      // node 2: start, data, stop
      ops[2] = 'hFA05; tick();
      chk("grant_owner2", 32'(bus.owner), 32'd2);
      ops[2] = 'h00C3; tick();
      chk("data_c3", 32'(bus.out_peripheral), 32'h0000_00C3);
      ops[2] = 'hFAFF; tick();
      chk("stop_hold_c3", 32'(bus.out_peripheral), 32'h0000_00C3);
      ops[2] = 0; tick();

      // priority: node 3 beats node 0, node 0 data ignored while node 3 holds
      ops[0] = 'hFA07; ops[3] = 'hFA0C; tick();
      chk("prio_owner3", 32'(bus.owner), 32'd3);
      ops[0] = 0; ops[3] = 'h0022; tick();
      ops[0] = 'h0011; ops[3] = 0; tick();
      chk("non_owner_data", 32'(bus.out_peripheral), 32'h0000_0022);
      ops[0] = 0; ops[3] = 'h0FA05; tick();
      chk("owner_restart_zero", 32'(bus.out_peripheral), 32'd0);
      ops[3] = 'hFAFF; tick();
      clear_ops(); tick();

      // round-robin between equal-priority nodes 1 and 2
      RST = 1'b1; tick(); RST = 1'b0;
      for (int g = 0; g < 4; g++) begin
         ops[1] = 'hFA04; ops[2] = 'hFA04; tick();
         chk("rr_grant", 32'(bus.owner), (g % 2 == 0) ? 32'd1 : 32'd2);
         ops[(g % 2 == 0) ? 1 : 2] = 'hFAFF; tick();
         chk("rr_release", 32'(bus.locked), 32'd0);
      end
      clear_ops(); tick();

      // hold timeout
      RST = 1'b1; tick(); RST = 1'b0;
      ops[0] = 'hFA01; tick();
      ops[0] = 'h0055; tick();
      ops[0] = 0;
`ifdef PERIPH_MUTEX_TIMEOUT_EN
      for (int i = 0; i < HT - 1; i++) tick();
      chk("pre_timeout_locked", 32'(bus.locked), 32'd1);
      tick();
      chk("timeout_release", 32'(bus.locked), 32'd0);
      chk("timeout_pulse_hi", 32'(bus.timeout_pulse), 32'd1);
      chk("timeout_out_zero", 32'(bus.out_peripheral), 32'd0);
      tick();
      chk("timeout_pulse_lo", 32'(bus.timeout_pulse), 32'd0);
`else
      for (int i = 0; i < 100; i++) tick();
      chk("no_timeout_locked", 32'(bus.locked), 32'd1);
      chk("no_timeout_out", 32'(bus.out_peripheral), 32'h0000_0055);
`endif
      ops[0] = 'hFAFF; tick();
      clear_ops(); tick();

      // reset mid-hold
      ops[1] = 'hFA03; tick();
      ops[1] = 'h00AA; tick();
      chk("pre_rst_data", 32'(bus.out_peripheral), 32'h0000_00AA);
      RST = 1'b1; tick();
      chk("rst_out", 32'(bus.out_peripheral), 32'd0);
      chk("rst_locked", 32'(bus.locked), 32'd0);
      chk("rst_owner", 32'(bus.owner), 32'd0);
      chk("rst_tp", 32'(bus.timeout_pulse), 32'd0);
      RST = 1'b0;

      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int k = 0; k < NN; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 35)      ops[k] = 'hFA00 | int'($urandom_range(0, 15));
            else if (r < 45) ops[k] = 'hFAFF;
            else if (r < 70) ops[k] = 0;
            else             ops[k] = int'($urandom & 32'h0000_FFFF);
         end
         RST = ($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0;
         tick();
      end
      RST = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
